// File: rtl/instr_chain_loader.sv
// instr_chain_loader: head-of-chain master for the cell array instruction
// load daisy chain and the call/ret handshake.
// Sequence per run: pulse array reset, stream (hops, addr, data) words into
// the chain one per cycle, let the chain drain, issue one call pulse, then
// wait for the aggregated ret from the array.
// Optional build macro: LOADER_TIMEOUT_EN adds a ret watchdog that ends the
// run in ERROR after TIMEOUT_CYCLES cycles without ret_in.
module instr_chain_loader #(
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int INSTR_ADDR_WIDTH = 6,
    parameter int INSTR_HOPS_WIDTH = 4,
    parameter int ARRAY_RST_CYCLES = 4,
    parameter int DRAIN_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [INSTR_DATA_WIDTH-1:0] s_data,
    input  logic [INSTR_ADDR_WIDTH-1:0] s_addr,
    input  logic [INSTR_HOPS_WIDTH-1:0] s_hops,
    input  logic                        s_last,
    output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
    output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
    output logic                        instr_en_out,
    output logic                        array_rst_n,
    output logic                        call_out,
    input  logic                        ret_in,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    typedef enum logic [2:0] {
        IDLE,
        RESET_ARRAY,
        LOAD,
        DRAIN,
        CALL,
        WAIT_RET,
        DONE,
        ERROR
    } state_t;

    localparam logic [31:0] RST_LAST   = 32'(ARRAY_RST_CYCLES - 1);
    // DRAIN is entered on the cycle the last strobe is driven; counting up to
    // DRAIN_CYCLES leaves DRAIN_CYCLES idle chain cycles before the call.
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES);
`ifdef LOADER_TIMEOUT_EN
    localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
`endif

    state_t state_q, state_d;
    logic [31:0] cnt_q, cnt_d;

    logic [INSTR_DATA_WIDTH-1:0] data_q;
    logic [INSTR_ADDR_WIDTH-1:0] addr_q;
    logic [INSTR_HOPS_WIDTH-1:0] hops_q;
    logic                        en_q;
    logic                        arst_n_q;
    logic                        accept;

    assign s_ready = (state_q == LOAD);
    assign accept  = s_valid && s_ready;

    // Next-state and phase counter; the counter clears whenever the state changes.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) state_d = RESET_ARRAY;
            end
            RESET_ARRAY: begin
                if (cnt_q == RST_LAST) state_d = LOAD;
                else                   cnt_d   = cnt_q + 32'd1;
            end
            LOAD: begin
                if (accept && s_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) state_d = CALL;
                else                     cnt_d   = cnt_q + 32'd1;
            end
            CALL: begin
                state_d = WAIT_RET;
            end
            WAIT_RET: begin
                if (ret_in) begin
                    state_d = DONE;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Chain word register: one-cycle latency, fields forced to zero without a strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
            hops_q <= '0;
        end else begin
            en_q   <= accept;
            data_q <= accept ? s_data : '0;
            addr_q <= accept ? s_addr : '0;
            hops_q <= accept ? s_hops : '0;
        end
    end

    // Registered array reset: low while in RESET_ARRAY and during rst_n.
    always_ff @(posedge clk) begin
        if (!rst_n) arst_n_q <= 1'b0;
        else        arst_n_q <= (state_d != RESET_ARRAY);
    end

    assign instr_data_out = data_q;
    assign instr_addr_out = addr_q;
    assign instr_hops_out = hops_q;
    assign instr_en_out   = en_q;
    assign array_rst_n    = arst_n_q;
    assign call_out       = (state_q == CALL);
    assign busy           = !(state_q inside {IDLE, DONE, ERROR});
    assign done           = (state_q == DONE);
`ifdef LOADER_TIMEOUT_EN
    assign error          = (state_q == ERROR);
`else
    assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_instr_chain_loader.sv
// Directed bench for instr_chain_loader (ARRAY_RST_CYCLES=4, DRAIN_CYCLES=16,
// TIMEOUT_CYCLES=100). Cycle tables cover two full runs; hand sequences cover
// mid-load reset and the ret watchdog (LOADER_TIMEOUT_EN).
module tb_instr_chain_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, s_valid, s_last, ret_in;
    logic [31:0] s_data;
    logic [5:0]  s_addr;
    logic [3:0]  s_hops;
    logic        s_ready, instr_en_out, array_rst_n, call_out, busy, done, error;
    logic [31:0] instr_data_out;
    logic [5:0]  instr_addr_out;
    logic [3:0]  instr_hops_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_chain_loader #(
        .INSTR_DATA_WIDTH(32),
        .INSTR_ADDR_WIDTH(6),
        .INSTR_HOPS_WIDTH(4),
        .ARRAY_RST_CYCLES(4),
        .DRAIN_CYCLES(16),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_addr(s_addr),
        .s_hops(s_hops), .s_last(s_last),
        .instr_data_out(instr_data_out), .instr_addr_out(instr_addr_out),
        .instr_hops_out(instr_hops_out), .instr_en_out(instr_en_out),
        .array_rst_n(array_rst_n), .call_out(call_out), .ret_in(ret_in),
        .busy(busy), .done(done), .error(error)
    );

    typedef struct {
        logic        start, valid, last, ret;
        logic [31:0] data;
        logic [5:0]  addr;
        logic [3:0]  hops;
        logic        e_ready, e_en, e_arst, e_call, e_busy, e_done;
        logic [31:0] e_data;
        logic [5:0]  e_addr;
        logic [3:0]  e_hops;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] wd [3] = '{32'hA0000001, 32'hA0000002, 32'hA0000003};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // w: word index to drive, -1 none, -2 junk word with last set; ew: expected strobe word or -1
    task automatic push(input logic st, input int w, input logic rt, input logic rdy, input int ew,
                        input logic arst, input logic call, input logic bsy, input logic dn);
        vec_t v;
        v = '{default: '0};
        v.start = st;
        v.ret   = rt;
        if (w >= 0) begin
            v.valid = 1'b1; v.data = wd[w]; v.addr = 6'(w); v.hops = 4'(w); v.last = (w == 2);
        end else if (w == -2) begin
            v.valid = 1'b1; v.data = 32'hDEADBEEF; v.addr = 6'h3F; v.hops = 4'hF; v.last = 1'b1;
        end
        v.e_ready = rdy;
        if (ew >= 0) begin
            v.e_en = 1'b1; v.e_data = wd[ew]; v.e_addr = 6'(ew); v.e_hops = 4'(ew);
        end
        v.e_arst = arst; v.e_call = call; v.e_busy = bsy; v.e_done = dn;
        tbl.push_back(v);
    endtask

    task automatic drive_word(input logic [31:0] d, input logic [5:0] a, input logic [3:0] h,
                              input logic l);
        s_valid = 1'b1; s_data = d; s_addr = a; s_hops = h; s_last = l;
    endtask

    // Start from an idle-like state, measure array reset / ready timing,
    // load one last word and measure the strobe-to-call distance.
    task automatic run_single(output int low, output int rdy_at, output int gap);
        low = 0; rdy_at = 0; gap = 0;
        @(negedge clk); start = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk); start = 1'b0; #1;
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) begin @(negedge clk); #1; end
            if (!array_rst_n) low++;
            if (s_ready) begin rdy_at = i; break; end
        end
        drive_word(32'h5A5A0001, 6'd7, 4'd3, 1'b1);
        @(negedge clk); s_valid = 1'b0; s_last = 1'b0; #1;
        chk("single.en", instr_en_out, 1);
        chk("single.data", instr_data_out, 32'h5A5A0001);
        chk("single.addr", instr_addr_out, 7);
        chk("single.hops", instr_hops_out, 3);
        chk("single.ready_drop", s_ready, 0);
        for (int g = 1; g <= 40; g++) begin
            @(negedge clk); #1;
            if (call_out) begin gap = g; break; end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low, rdy_at, gap, calls, first_err, err_hi, busy_lo;

        // Run A: back-to-back words, stale ret during reset/load, start ignored in DRAIN
        push(1, -1, 0, 0, -1, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) push(0, -1, 1, 0, -1, 0, 0, 1, 0);
        push(0, 0, 1, 1, -1, 1, 0, 1, 0);
        push(0, 1, 1, 1, 0, 1, 0, 1, 0);
        push(0, 2, 1, 1, 1, 1, 0, 1, 0);
        push(0, -1, 0, 0, 2, 1, 0, 1, 0);
        for (int i = 9; i <= 24; i++) push(i == 12, -1, 0, 0, -1, 1, 0, 1, 0);
        push(0, -1, 0, 0, -1, 1, 1, 1, 0);
        push(0, -1, 0, 0, -1, 1, 0, 1, 0);
        push(0, -1, 0, 0, -1, 1, 0, 1, 0);
        push(0, -1, 1, 0, -1, 1, 0, 1, 0);
        push(0, -1, 1, 0, -1, 1, 0, 0, 1);
        push(0, -1, 1, 0, -1, 1, 0, 0, 1);
        // Run B: restart from DONE, gapped words, junk offered while not ready
        push(1, -1, 1, 0, -1, 1, 0, 0, 1);
        for (int i = 1; i <= 4; i++) push(0, -2, 0, 0, -1, 0, 0, 1, 0);
        push(0, 0, 0, 1, -1, 1, 0, 1, 0);
        push(0, -1, 0, 1, 0, 1, 0, 1, 0);
        push(0, 1, 0, 1, -1, 1, 0, 1, 0);
        push(0, -1, 0, 1, 1, 1, 0, 1, 0);
        push(0, 2, 0, 1, -1, 1, 0, 1, 0);
        push(0, -2, 0, 0, 2, 1, 0, 1, 0);
        push(0, -2, 0, 0, -1, 1, 0, 1, 0);
        push(0, -2, 0, 0, -1, 1, 0, 1, 0);
        for (int i = 13; i <= 26; i++) push(0, -1, 0, 0, -1, 1, 0, 1, 0);
        push(0, -1, 0, 0, -1, 1, 1, 1, 0);
        push(0, -1, 1, 0, -1, 1, 0, 1, 0);
        push(0, -1, 1, 0, -1, 1, 0, 0, 1);

        // Reset with start held and stale ret
        rst_n = 1'b0; start = 1'b1; ret_in = 1'b1;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_addr = '0; s_hops = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.ready", s_ready, 0);
        chk("rst.en", instr_en_out, 0);
        chk("rst.data", instr_data_out, 0);
        chk("rst.arst", array_rst_n, 0);
        chk("rst.call", call_out, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.error", error, 0);
        @(negedge clk); rst_n = 1'b1; start = 1'b0; ret_in = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start = tbl[i].start; s_valid = tbl[i].valid; s_last = tbl[i].last;
            ret_in = tbl[i].ret; s_data = tbl[i].data; s_addr = tbl[i].addr; s_hops = tbl[i].hops;
            #1;
            chk($sformatf("v%0d.ready", i), s_ready, tbl[i].e_ready);
            chk($sformatf("v%0d.en", i), instr_en_out, tbl[i].e_en);
            chk($sformatf("v%0d.data", i), instr_data_out, tbl[i].e_data);
            chk($sformatf("v%0d.addr", i), instr_addr_out, tbl[i].e_addr);
            chk($sformatf("v%0d.hops", i), instr_hops_out, tbl[i].e_hops);
            chk($sformatf("v%0d.arst", i), array_rst_n, tbl[i].e_arst);
            chk($sformatf("v%0d.call", i), call_out, tbl[i].e_call);
            chk($sformatf("v%0d.busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d.done", i), done, tbl[i].e_done);
            chk($sformatf("v%0d.error", i), error, 0);
        end

        // Mid-load reset after two of four words
        @(negedge clk); start = 1'b1; s_valid = 1'b0; s_last = 1'b0; ret_in = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk); drive_word(32'hB0000001, 6'd4, 4'd1, 1'b0); #1;
        chk("mid.ready", s_ready, 1);
        @(negedge clk); drive_word(32'hB0000002, 6'd5, 4'd2, 1'b0); #1;
        chk("mid.en1", instr_en_out, 1);
        chk("mid.data1", instr_data_out, 32'hB0000001);
        @(negedge clk); drive_word(32'hB0000003, 6'd6, 4'd3, 1'b0); rst_n = 1'b0; #1;
        chk("mid.en2", instr_en_out, 1);
        chk("mid.data2", instr_data_out, 32'hB0000002);
        @(negedge clk); s_valid = 1'b0; #1;
        chk("mid.rst.ready", s_ready, 0);
        chk("mid.rst.en", instr_en_out, 0);
        chk("mid.rst.data", instr_data_out, 0);
        chk("mid.rst.addr", instr_addr_out, 0);
        chk("mid.rst.hops", instr_hops_out, 0);
        chk("mid.rst.arst", array_rst_n, 0);
        chk("mid.rst.busy", busy, 0);
        chk("mid.rst.done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        calls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (call_out) calls++;
        end
        chk("mid.no_call", calls, 0);
        chk("mid.idle_busy", busy, 0);
        chk("mid.idle_arst", array_rst_n, 1);

        // Fresh run after the abandoned load
        run_single(low, rdy_at, gap);
        chk("fresh.arst_low_cycles", low, 4);
        chk("fresh.ready_cycle", rdy_at, 5);
        chk("fresh.drain_gap", gap, 17);
        @(negedge clk); ret_in = 1'b1; #1;
        chk("fresh.call_one_cycle", call_out, 0);
        chk("fresh.busy_wait", busy, 1);
        @(negedge clk); #1;
        chk("fresh.done", done, 1);
        chk("fresh.busy_end", busy, 0);
        @(negedge clk); ret_in = 1'b0;

        // Ret watchdog
        run_single(low, rdy_at, gap);
        chk("wd.drain_gap", gap, 17);
`ifdef LOADER_TIMEOUT_EN
        first_err = -1;
        for (int k = 0; k <= 120; k++) begin
            @(negedge clk); #1;
            if (error) begin first_err = k; break; end
        end
        chk("wd.error_cycle", first_err, 100);
        chk("wd.done", done, 0);
        chk("wd.busy", busy, 0);
        @(negedge clk); start = 1'b1; #1;
        chk("wd.error_hold", error, 1);
        @(negedge clk); start = 1'b0; #1;
        chk("wd.error_clear", error, 0);
        chk("wd.restart_busy", busy, 1);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
`else
        err_hi = 0; busy_lo = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk); #1;
            if (error) err_hi++;
            if (!busy) busy_lo++;
        end
        chk("wait.error_never", err_hi, 0);
        chk("wait.busy_held", busy_lo, 0);
        @(negedge clk); ret_in = 1'b1;
        @(negedge clk); #1;
        chk("wait.late_done", done, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
